processador_multiciclo_param: RTL and testbench
===============================================

Name: processador_multiciclo_param

Overview:
Parametrised multicycle processor, successor to the fixed 16-bit, 8-register core. Data width and register-file size are parameters. The ALU instruction set grows to add/sub/and/slt, plus conditional move (mvnz) and an immediate move (mvi). The step counter Tstep is exported for bench observation. One instruction executes per Run pulse over 2–4 cycles, on a single shared bus (BusWires) fed from DIN, the register file, or G.

Parameters:
DATA_W, 16, width of DIN, BusWires, registers, A and G; must be >= 3+2*RSEL_W
RSEL_W, 3, register-select field width; NUM_REGS = 2**RSEL_W

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Run  input  1  start request, sampled only in T0
DIN  input  DATA_W  instruction word (T0) or immediate (mvi T1)
Done  output  1  high during the final step of an instruction (combinational)
BusWires  output  DATA_W  shared bus value (combinational mux)
Tstep  output  2  current step T0..T3

Behaviour:
- Reset (async, high): Tstep=0, IR=0, A=0, G=0, all R[i]=0, Done=0, BusWires=0. Reset mid-instruction aborts it; no partial write survives.
- IR = DIN[3+2*RSEL_W-1:0] = {op[2:0], Rx[RSEL_W-1:0], Ry[RSEL_W-1:0]}; op is the MSBs. DIN bits above the IR field are ignored.
- Opcodes:
  - 000 mv Rx<-Ry
  - 001 mvi Rx<-DIN
  - 010 add
  - 011 sub
  - 100 and
  - 101 slt (Rx<-1 if signed Rx<Ry, else 0)
  - 110 mvnz (Rx<-Ry if G!=0)
  - 111 nop
- T0:
  - If Run=1 at the edge, IR<-DIN and Tstep->1.
  - Otherwise stay in T0; BusWires=0 and Done=0.
- T1:
  - mv: bus=R[Ry], Rx loads, Done=1, next T0.
  - mvi: bus=DIN, Rx loads, Done=1, next T0.
  - mvnz: bus=R[Ry]; Rx loads only if G!=0; Done=1, next T0.
  - nop: bus=0, Done=1, next T0.
  - ALU ops: bus=R[Rx], A loads, Done=0, next T2.
- T2 (ALU ops only): bus=R[Ry]; G<-A op bus; next T3.
- T3 (ALU ops only): bus=G, Rx loads, Done=1, next T0.
- Arithmetic:
  - add/sub are modulo 2**DATA_W; no flags, overflow discarded.
  - and is bitwise.
  - slt is a two's-complement compare; the result is zero-extended 1 or 0.
- G holds its value until the next ALU instruction; mvnz tests G as left by the last ALU op (G=0 after reset).
- Latency:
  - mv/mvi/mvnz/nop: 2 cycles from the Run-sampling edge to the T0 return.
  - ALU ops: 4 cycles.
- Run held high runs instructions back-to-back: the next IR loads at the T0 edge following Done.
- Run changes outside T0 have no effect.
- Rx==Ry is legal: add R0,R0 doubles R0.
- Exactly one bus source is active per step.
- Register writes occur only at the rising edge in the step listed above.

Test Plan:
1. Reset=1 then 0; Run=1, DIN=0x0048 (mvi R1); next cycle DIN=0x0005 -> T1: BusWires=0x0005, Done=1, Tstep=1; after the edge R1=5, Tstep=0.
2. Run=1, DIN=0x0001 (mv R0,R1) -> T1: BusWires=0x0005, Done=1; R0=5.
3. DIN=0x0081 (add R0,R1) -> T1 bus=5 with Done=0; T2 bus=5; T3 bus=0x000A with Done=1; R0=0x000A.
4. DIN=0x00C8 (sub R1,R0) -> R1=0xFFFB. Then slt R2,R1 (DIN=0x0151) with R2=0 -> R2=0, since 0 < -5 is false.
5. mvnz R3,R0 (DIN=0x0198) after the step-4 slt left G=0 -> R3 stays 0, Done in T1. Re-run after add (G!=0) -> R3=0x000A.
6. Reset=1 asserted asynchronously mid-T2 of an add -> Tstep=0, Done=0, BusWires=0, all R=0 immediately. With Run held high across 3 instructions -> each starts at the T0 edge directly after Done.

Source files
------------

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor.
// A single shared bus carries DIN, a register-file entry or G. Each instruction
// takes 2 to 4 steps: mv, mvi, mvnz and nop finish in T1. The ALU ops
// (add/sub/and/slt) stage the first operand in A during T1, compute into G
// during T2 and write back during T3.
module processador_multiciclo_param #(
    parameter int DATA_W = 16,
    parameter int RSEL_W = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic [1:0]        Tstep
);

    localparam int NUM_REGS = 2 ** RSEL_W;
    localparam int IR_W     = 3 + 2 * RSEL_W;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t              step_q, step_d;
    logic [IR_W-1:0]    ir_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  g_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];

    logic [2:0]         op;
    logic [RSEL_W-1:0]  rx;
    logic [RSEL_W-1:0]  ry;
    logic               rx_we;
    logic               a_we;
    logic               g_we;
    logic [DATA_W-1:0]  alu_res;

    // DIN bits above the instruction field carry no meaning for decode.
    generate
        if (DATA_W > IR_W) begin : g_din_hi
            logic din_hi_unused;
            assign din_hi_unused = ^DIN[DATA_W-1:IR_W];
        end
    endgenerate

    assign op    = ir_q[IR_W-1 -: 3];
    assign rx    = ir_q[2*RSEL_W-1 -: RSEL_W];
    assign ry    = ir_q[RSEL_W-1:0];
    assign Tstep = step_q;

    // Step sequencing, bus source selection, Done and write enables.
    always_comb begin
        BusWires = '0;
        Done     = 1'b0;
        step_d   = step_q;
        rx_we    = 1'b0;
        a_we     = 1'b0;
        g_we     = 1'b0;
        case (step_q)
            T0: begin
                if (Run) begin
                    step_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        BusWires = regs_q[ry];
                        rx_we    = 1'b1;
                        Done     = 1'b1;
                        step_d   = T0;
                    end
                    OP_MVI: begin
                        BusWires = DIN;
                        rx_we    = 1'b1;
                        Done     = 1'b1;
                        step_d   = T0;
                    end
                    OP_MVNZ: begin
                        // The bus still shows Ry; only the write is gated by G.
                        BusWires = regs_q[ry];
                        rx_we    = (g_q != '0);
                        Done     = 1'b1;
                        step_d   = T0;
                    end
                    OP_NOP: begin
                        Done   = 1'b1;
                        step_d = T0;
                    end
                    default: begin
                        BusWires = regs_q[rx];
                        a_we     = 1'b1;
                        step_d   = T2;
                    end
                endcase
            end
            T2: begin
                BusWires = regs_q[ry];
                g_we     = 1'b1;
                step_d   = T3;
            end
            T3: begin
                BusWires = g_q;
                rx_we    = 1'b1;
                Done     = 1'b1;
                step_d   = T0;
            end
            default: begin
                step_d = T0;
            end
        endcase
    end

    // ALU: A combined with the Ry operand currently on the bus.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_q + BusWires;
            OP_SUB:  alu_res = a_q - BusWires;
            OP_AND:  alu_res = a_q & BusWires;
            OP_SLT:  alu_res[0] = ($signed(a_q) < $signed(BusWires));
            default: alu_res = '0;
        endcase
    end

    // Step register, instruction register and the A/G operand registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
        end else begin
            step_q <= step_d;
            if (step_q == T0 && Run) begin
                ir_q <= DIN[IR_W-1:0];
            end
            if (a_we) begin
                a_q <= BusWires;
            end
            if (g_we) begin
                g_q <= alu_res;
            end
        end
    end

    // Register file: each entry loads from the bus when it is the selected Rx.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            // Entry gi captures BusWires on a write step that targets it.
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    regs_q[gi] <= '0;
                end else if (rx_we && (rx == RSEL_W'(gi))) begin
                    regs_q[gi] <= BusWires;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Bench for processador_multiciclo_param (DATA_W=16, RSEL_W=3).
// Stimulus tasks queue the hand-computed per-step bus/Done/Tstep values of each
// instruction, plus the T0 return that follows Done. A monitor on the falling
// edge pops and compares one entry per non-idle step. Register contents are
// observed by issuing mv Rk,Rk, which puts R[k] on the bus without changing it.
module tb_processador_multiciclo_param;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [15:0] DIN;
    logic        Done;
    logic [15:0] BusWires;
    logic [1:0]  Tstep;

    typedef struct packed {
        logic [1:0]  t;
        logic [15:0] bus;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   vectors   = 0;
    int   fails     = 0;
    bit   prev_done = 1'b0;

    processador_multiciclo_param #(.DATA_W(16), .RSEL_W(3)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Run      (Run),
        .DIN      (DIN),
        .Done     (Done),
        .BusWires (BusWires),
        .Tstep    (Tstep)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry);
        return {7'd0, op, rx, ry};
    endfunction

    task automatic push(input logic [1:0] t, input logic [15:0] b, input logic d);
        exp_t e;
        e.t    = t;
        e.bus  = b;
        e.done = d;
        q.push_back(e);
    endtask

    // Issue at a falling edge in T0, then wait for the monitor to drain the queue.
    task automatic run_instr(input logic [15:0] instr, input logic [15:0] imm, input bit hold);
        DIN = instr;
        Run = 1'b1;
        @(posedge Clock);
        #1;
        DIN = imm;
        Run = hold;
        for (int i = 0; i < 12 && q.size() != 0; i++) begin
            @(negedge Clock);
            #1;
        end
        if (q.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL timeout instr=%h: %0d steps still pending, required 0", instr, q.size());
            q.delete();
        end
    endtask

    task automatic short_op(input logic [15:0] instr, input logic [15:0] imm,
                            input logic [15:0] b1, input bit hold);
        push(2'd1, b1, 1'b1);
        push(2'd0, 16'h0000, 1'b0);
        run_instr(instr, imm, hold);
    endtask

    task automatic alu_op(input logic [15:0] instr, input logic [15:0] b1,
                          input logic [15:0] b2, input logic [15:0] b3, input bit hold);
        push(2'd1, b1, 1'b0);
        push(2'd2, b2, 1'b0);
        push(2'd3, b3, 1'b1);
        push(2'd0, 16'h0000, 1'b0);
        run_instr(instr, 16'h0000, hold);
    endtask

    task automatic read_reg(input logic [2:0] k, input logic [15:0] expv);
        short_op(enc(3'b000, k, k), 16'h0000, expv, 1'b0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor: every step other than idle T0 must match the next queued entry.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset) begin
            prev_done = 1'b0;
        end else if (Tstep != 2'd0 || prev_done) begin
            vectors++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_step: Tstep=%0d bus=%h done=%b, required idle T0",
                         Tstep, BusWires, Done);
            end else begin
                e = q.pop_front();
                if (Tstep !== e.t || BusWires !== e.bus || Done !== e.done) begin
                    fails++;
                    $display("FAIL step: got T%0d bus=%h done=%b, required T%0d bus=%h done=%b",
                             Tstep, BusWires, Done, e.t, e.bus, e.done);
                end else begin
                    $display("ok   step T%0d bus=%h done=%b", Tstep, BusWires, Done);
                end
            end
            prev_done = Done;
        end else begin
            vectors++;
            if (Done !== 1'b0 || BusWires !== 16'h0000) begin
                fails++;
                $display("FAIL idle_t0: got bus=%h done=%b, required bus=0000 done=0",
                         BusWires, Done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Run   = 1'b1;
        DIN   = 16'h0048;
        repeat (2) @(negedge Clock);
        #1;
        chk("reset_tstep", {14'd0, Tstep}, 16'd0);
        chk("reset_done", {15'd0, Done}, 16'd0);
        chk("reset_bus", BusWires, 16'h0000);
        Run   = 1'b0;
        Reset = 1'b0;

        // mvi R1,5 then mv R0,R1 and add R0,R1
        short_op(16'h0048, 16'h0005, 16'h0005, 1'b0);
        read_reg(3'd1, 16'h0005);
        short_op(16'h0001, 16'h0000, 16'h0005, 1'b0);
        alu_op(16'h0081, 16'h0005, 16'h0005, 16'h000A, 1'b0);
        read_reg(3'd0, 16'h000A);

        // sub R1,R0 wraps to -5; slt R2,R1: 0 < -5 is false, G becomes 0
        alu_op(16'h00C8, 16'h0005, 16'h000A, 16'hFFFB, 1'b0);
        alu_op(16'h0151, 16'h0000, 16'hFFFB, 16'h0000, 1'b0);

        // mvnz R3,R0 with G=0 leaves R3; after add R4,R0 (G=A) it loads
        short_op(16'h0198, 16'h0000, 16'h000A, 1'b0);
        read_reg(3'd3, 16'h0000);
        alu_op(16'h00A0, 16'h0000, 16'h000A, 16'h000A, 1'b0);
        short_op(16'h0198, 16'h0000, 16'h000A, 1'b0);
        read_reg(3'd3, 16'h000A);

        // slt R1,R0: -5 < 10 true; and R0,R1: A & 1 = 0; nop; ignored DIN MSBs
        alu_op(16'h0148, 16'hFFFB, 16'h000A, 16'h0001, 1'b0);
        alu_op(16'h0101, 16'h000A, 16'h0001, 16'h0000, 1'b0);
        short_op(16'h01C0, 16'h0000, 16'h0000, 1'b0);
        short_op(16'hFE09, 16'h0000, 16'h0001, 1'b0);

        // add R4,R4 doubles; sub R0,R4: 0 - 0x14 wraps to FFEC
        alu_op(16'h00A4, 16'h000A, 16'h000A, 16'h0014, 1'b0);
        alu_op(16'h00C4, 16'h0000, 16'h0014, 16'hFFEC, 1'b0);

        // Asynchronous reset in the middle of T2 of add R4,R4
        push(2'd1, 16'h0014, 1'b0);
        DIN = 16'h00A4;
        Run = 1'b1;
        @(posedge Clock);
        #1;
        Run = 1'b0;
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        chk("midreset_tstep", {14'd0, Tstep}, 16'd0);
        chk("midreset_done", {15'd0, Done}, 16'd0);
        chk("midreset_bus", BusWires, 16'h0000);
        if (q.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL midreset_t1: %0d entries not seen, required 0", q.size());
            q.delete();
        end
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            read_reg(3'(k), 16'h0000);
        end

        // G cleared by reset: mvnz R3,R1 must not load
        short_op(16'h0048, 16'h0009, 16'h0009, 1'b0);
        short_op(16'h0199, 16'h0000, 16'h0009, 1'b0);
        read_reg(3'd3, 16'h0000);

        // Run held high: three instructions back to back, one T0 between each
        short_op(16'h0048, 16'h0007, 16'h0007, 1'b1);
        short_op(16'h0011, 16'h0000, 16'h0007, 1'b1);
        alu_op(16'h0091, 16'h0007, 16'h0007, 16'h000E, 1'b0);
        read_reg(3'd2, 16'h000E);

        repeat (2) @(negedge Clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
